// File: rtl/div_by_5_bit_source.sv
// div_by_5_bit_source: serialises WIDTH-bit words MSB-first for the div_by_5 receiver and
// tracks the running remainder (mod DIVISOR) of the bits emitted so far in each frame.
module div_by_5_bit_source #(
   parameter  int unsigned WIDTH   = 10,
   parameter  int unsigned DIVISOR = 5,
   localparam int unsigned RW      = $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             pause,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last,
   output logic [RW-1:0]    exp_rem,
   output logic             exp_divisible
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sreg, sreg_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [RW-1:0]    rem_acc, rem_d;
   logic [RW:0]      rem_dbl;
   logic [RW-1:0]    rem_next;
   logic             in_shift;
   logic             at_last;
   logic [WIDTH-1:0] sreg_shifted;

   // Status decode from the registered state
   always_comb begin
      in_shift     = (state == SHIFT);
      at_last      = in_shift && (cnt == '0);
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
   end

   // Remainder step: {rem_acc, bit} == 2*rem_acc + bit, which is below 2*DIVISOR,
   // so one conditional subtract brings it back into range
   always_comb begin
      rem_dbl = {rem_acc, sreg[WIDTH-1]};
      if (rem_dbl >= (RW+1)'(DIVISOR)) begin
         rem_next = RW'(rem_dbl - (RW+1)'(DIVISOR));
      end else begin
         rem_next = RW'(rem_dbl);
      end
   end

   // Serial outputs, forced to zero outside a frame
   always_comb begin
      out_valid     = in_shift;
      out_bit       = in_shift && sreg[WIDTH-1];
      out_last      = at_last;
      exp_rem       = in_shift ? rem_next : '0;
      exp_divisible = in_shift && (rem_next == '0);
   end

   // Next-state and load handshake; a paused frame holds everything
   always_comb begin
      state_d    = state;
      sreg_d     = sreg;
      cnt_d      = cnt;
      rem_d      = rem_acc;
      load_ready = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               state_d = SHIFT;
               sreg_d  = load_data;
               cnt_d   = CW'(WIDTH - 1);
               rem_d   = '0;
            end
         end
         SHIFT: begin
            if (!pause) begin
               if (at_last) begin
                  // Final bit: chain straight into the next word when one is offered
                  load_ready = 1'b1;
                  if (load_valid) begin
                     sreg_d = load_data;
                     cnt_d  = CW'(WIDTH - 1);
                     rem_d  = '0;
                  end else begin
                     state_d = IDLE;
                     sreg_d  = sreg_shifted;
                     rem_d   = rem_next;
                  end
               end else begin
                  sreg_d = sreg_shifted;
                  cnt_d  = cnt - CW'(1);
                  rem_d  = rem_next;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         rem_acc <= '0;
      end else begin
         state   <= state_d;
         sreg    <= sreg_d;
         cnt     <= cnt_d;
         rem_acc <= rem_d;
      end
   end

endmodule

// File: tb/tb_div_by_5_bit_source.sv
// Testbench for div_by_5_bit_source: queue scoreboard of expected bits/remainders per frame.
`timescale 1ns/1ps
module tb_div_by_5_bit_source;

   localparam int unsigned WIDTH   = 10;
   localparam int unsigned DIVISOR = 5;
   localparam int unsigned RW      = $clog2(DIVISOR);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             load_valid = 1'b0;
   logic             pause = 1'b0;
   logic [WIDTH-1:0] load_data = '0;
   logic             load_ready, out_bit, out_valid, out_last, exp_divisible;
   logic [RW-1:0]    exp_rem;

   typedef struct packed {
      logic          b;
      logic [RW-1:0] rem;
      logic          last;
   } exp_t;

   exp_t expq[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   div_by_5_bit_source dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .pause(pause), .out_bit(out_bit), .out_valid(out_valid),
      .out_last(out_last), .exp_rem(exp_rem), .exp_divisible(exp_divisible)
   );

   // Expected per-bit values: remainder of the whole prefix value taken directly
   function automatic void push_word(input logic [WIDTH-1:0] w);
      exp_t        e;
      int unsigned prefix;
      for (int i = 0; i < int'(WIDTH); i++) begin
         prefix = 32'(w >> (WIDTH - 1 - i));
         e.b    = w[WIDTH-1-i];
         e.rem  = RW'(prefix % DIVISOR);
         e.last = (i == int'(WIDTH) - 1);
         expq.push_back(e);
      end
   endfunction

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      tests_run++;
      if ({load_ready, out_bit, out_valid, out_last, exp_rem, exp_divisible} !== {1'b1, 1'b0, 1'b0, 1'b0, RW'(0), 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_values: got rdy=%b b=%b v=%b last=%b rem=%0d div=%b, want rdy=1 rest 0",
                  load_ready, out_bit, out_valid, out_last, exp_rem, exp_divisible);
      end
      @(negedge clk) rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got v=%b rdy=%b, want v=0 rdy=1", out_valid, load_ready);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 10'd170;
      #1;
      tests_run++;
      if (load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_ready: got %b, want 1", load_ready);
      end
      push_word(load_data);
      @(negedge clk) load_valid = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         #1;
         tests_run++;
         if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL basic_underflow: bit %0d got v=%b, want no output", i, out_valid);
         end else begin
            e = expq.pop_front();
            if ({out_valid, out_bit, exp_rem, exp_divisible, out_last} !== {1'b1, e.b, e.rem, (e.rem == '0), e.last}) begin
               tests_failed++;
               $display("FAIL basic bit %0d: got v=%b b=%b rem=%0d div=%b last=%b, want v=1 b=%b rem=%0d div=%b last=%b",
                        i, out_valid, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
            end
         end
         @(negedge clk);
      end
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1 || exp_divisible !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_idle_after: got v=%b rdy=%b div=%b, want 0 1 0", out_valid, load_ready, exp_divisible);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   accepts = 0;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 10'd170;
      #1;
      push_word(load_data);
      @(negedge clk) load_data = 10'h3FF;
      for (int i = 0; i < 2 * int'(WIDTH); i++) begin
         #1;
         tests_run++;
         if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL b2b_underflow: cycle %0d got v=%b, want no output", i, out_valid);
         end else begin
            e = expq.pop_front();
            if ({out_valid, out_bit, exp_rem, exp_divisible, out_last} !== {1'b1, e.b, e.rem, (e.rem == '0), e.last}) begin
               tests_failed++;
               $display("FAIL b2b cycle %0d: got v=%b b=%b rem=%0d div=%b last=%b, want v=1 b=%b rem=%0d div=%b last=%b",
                        i, out_valid, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
            end
         end
         if (load_valid && load_ready) begin
            push_word(load_data);
            accepts++;
            tests_run++;
            if (i != int'(WIDTH) - 1) begin
               tests_failed++;
               $display("FAIL b2b_accept_cycle: got %0d, want %0d", i, WIDTH - 1);
            end
         end
         if (i == 2 * int'(WIDTH) - 1) begin
            tests_run++;
            if (exp_rem !== RW'(3) || exp_divisible !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_final_rem: got rem=%0d div=%b, want rem=3 div=0", exp_rem, exp_divisible);
            end
         end
         @(negedge clk);
         if (accepts > 0) load_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || accepts != 1) begin
         tests_failed++;
         $display("FAIL b2b_end: got v=%b accepts=%0d, want v=0 accepts=1", out_valid, accepts);
      end
   endtask

   task automatic test_pause();
      exp_t e;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 10'd170;
      #1;
      push_word(load_data);
      @(negedge clk) load_valid = 1'b0;
      for (int i = 0; i < 13; i++) begin
         pause = (i >= 4 && i <= 6);
         #1;
         tests_run++;
         if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL pause_underflow: cycle %0d got v=%b, want no output", i, out_valid);
         end else begin
            e = expq[0];
            if (!pause) void'(expq.pop_front());
            if ({out_valid, out_bit, exp_rem, exp_divisible, out_last} !== {1'b1, e.b, e.rem, (e.rem == '0), e.last}) begin
               tests_failed++;
               $display("FAIL pause cycle %0d: got v=%b b=%b rem=%0d div=%b last=%b, want v=1 b=%b rem=%0d div=%b last=%b",
                        i, out_valid, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
            end
         end
         if (i >= 4 && i <= 7) begin
            tests_run++;
            if (out_bit !== 1'b1 || exp_rem !== RW'(0)) begin
               tests_failed++;
               $display("FAIL pause_hold cycle %0d: got b=%b rem=%0d, want b=1 rem=0", i, out_bit, exp_rem);
            end
         end
         @(negedge clk);
      end
      pause = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_frame_len: got v=%b after 13 cycles, want 0", out_valid);
      end
   endtask

   task automatic test_pause_last();
      exp_t e;
      logic accepted = 1'b0;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 10'd170;
      #1;
      push_word(load_data);
      @(negedge clk) load_valid = 1'b0;
      for (int i = 0; i < 23; i++) begin
         pause      = (i >= 9 && i <= 11);
         load_valid = (i >= 9) && !accepted;
         load_data  = 10'd5;
         #1;
         tests_run++;
         if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL plast_underflow: cycle %0d got v=%b, want no output", i, out_valid);
         end else begin
            e = expq[0];
            if (!pause) void'(expq.pop_front());
            if ({out_valid, out_bit, exp_rem, exp_divisible, out_last} !== {1'b1, e.b, e.rem, (e.rem == '0), e.last}) begin
               tests_failed++;
               $display("FAIL plast cycle %0d: got v=%b b=%b rem=%0d div=%b last=%b, want v=1 b=%b rem=%0d div=%b last=%b",
                        i, out_valid, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
            end
         end
         if (pause) begin
            tests_run++;
            if (load_ready !== 1'b0 || out_last !== 1'b1) begin
               tests_failed++;
               $display("FAIL plast_ready cycle %0d: got rdy=%b last=%b, want rdy=0 last=1", i, load_ready, out_last);
            end
         end
         if (load_valid && load_ready) begin
            push_word(load_data);
            accepted = 1'b1;
            tests_run++;
            if (i != 12) begin
               tests_failed++;
               $display("FAIL plast_accept_cycle: got %0d, want 12", i);
            end
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || accepted !== 1'b1) begin
         tests_failed++;
         $display("FAIL plast_end: got v=%b accepted=%b, want v=0 accepted=1", out_valid, accepted);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 10'd170;
      #1;
      push_word(load_data);
      @(negedge clk) load_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         void'(expq.pop_front());
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if ({load_ready, out_bit, out_valid, out_last, exp_rem, exp_divisible} !== {1'b1, 1'b0, 1'b0, 1'b0, RW'(0), 1'b0}) begin
         tests_failed++;
         $display("FAIL midreset_async: got rdy=%b b=%b v=%b last=%b rem=%0d div=%b, want rdy=1 rest 0",
                  load_ready, out_bit, out_valid, out_last, exp_rem, exp_divisible);
      end
      expq.delete();
      @(negedge clk) rst = 1'b1;
      load_valid = 1'b1;
      load_data  = 10'd5;
      #1;
      push_word(load_data);
      @(negedge clk) load_valid = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         #1;
         tests_run++;
         if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL midreset_underflow: bit %0d got v=%b, want no output", i, out_valid);
         end else begin
            e = expq.pop_front();
            if ({out_valid, out_bit, exp_rem, exp_divisible, out_last} !== {1'b1, e.b, e.rem, (e.rem == '0), e.last}) begin
               tests_failed++;
               $display("FAIL midreset bit %0d: got v=%b b=%b rem=%0d div=%b last=%b, want v=1 b=%b rem=%0d div=%b last=%b",
                        i, out_valid, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
            end
         end
         if (i == int'(WIDTH) - 1) begin
            tests_run++;
            if (exp_rem !== RW'(0) || exp_divisible !== 1'b1 || out_last !== 1'b1) begin
               tests_failed++;
               $display("FAIL midreset_last: got rem=%0d div=%b last=%b, want 0 1 1", exp_rem, exp_divisible, out_last);
            end
         end
         @(negedge clk);
      end
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_idle: got v=%b, want 0", out_valid);
      end
   endtask

   // Random words with random pauses; a div-by-5 receiver model consumes out_bit
   task automatic test_random();
      exp_t        e;
      int          words = 0;
      int          cycles = 0;
      int unsigned rx_rem = 0;
      int unsigned nr;
      logic        done = 1'b0;
      while (!done && cycles < 40000) begin
         pause      = ($urandom_range(0, 4) == 0);
         load_valid = (words < 1000) && ($urandom_range(0, 3) != 0);
         load_data  = WIDTH'($urandom);
         #1;
         if (out_valid) begin
            tests_run++;
            if (expq.size() == 0) begin
               tests_failed++;
               $display("FAIL rand_underflow: cycle %0d unexpected out_valid", cycles);
            end else begin
               e = expq[0];
               if (!pause) void'(expq.pop_front());
               if ({out_bit, exp_rem, exp_divisible, out_last} !== {e.b, e.rem, (e.rem == '0), e.last}) begin
                  tests_failed++;
                  $display("FAIL rand cycle %0d: got b=%b rem=%0d div=%b last=%b, want b=%b rem=%0d div=%b last=%b",
                           cycles, out_bit, exp_rem, exp_divisible, out_last, e.b, e.rem, (e.rem == '0), e.last);
               end
            end
            if (!pause) begin
               nr = (2 * rx_rem + 32'(out_bit)) % DIVISOR;
               tests_run++;
               if (exp_divisible !== (nr == 0)) begin
                  tests_failed++;
                  $display("FAIL rx_is_divisible cycle %0d: got %b, want %b", cycles, exp_divisible, (nr == 0));
               end
               rx_rem = out_last ? 0 : nr;
            end
         end else begin
            tests_run++;
            if (exp_divisible !== 1'b0 || expq.size() != 0) begin
               tests_failed++;
               $display("FAIL rand_idle cycle %0d: got div=%b pending=%0d, want div=0 pending=0",
                        cycles, exp_divisible, expq.size());
            end
         end
         if (load_valid && load_ready) begin
            push_word(load_data);
            words++;
         end
         if (words == 1000 && expq.size() == 0) done = 1'b1;
         @(negedge clk);
         cycles++;
      end
      load_valid = 1'b0;
      pause      = 1'b0;
      tests_run++;
      if (!done) begin
         tests_failed++;
         $display("FAIL rand_timeout: got %0d words with %0d bits pending, want 1000 words drained", words, expq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_pause();
      test_pause_last();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
